cd_uplink_buf_2ch: RTL

- Two-lane elastic buffer directly downstream of the local 4x2 crossbar on the request path.
- Absorbs the crossbar's converged outputs (cv_so/cv_do) and drives the two global-network uplinks.
- Each lane is an independent DEPTH-entry FIFO. Lanes decouple global-link backpressure from crossbar arbitration.
- No combinational path exists from global ready to crossbar ready.

---
 rtl/cd_uplink_buf_2ch.sv | 81 ++++++++
 1 files changed

// File: rtl/cd_uplink_buf_2ch.sv
// Two-lane elastic buffer between the local crossbar and the global uplinks.
// Each lane is an independent FIFO; crossbar ready depends only on registered occupancy.
module cd_uplink_buf_2ch #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          cv_si,
   output logic [1:0]          cv_ri,
   input  logic [2*DATA_W-1:0] cv_di,
   output logic [1:0]          gl_so,
   input  logic [1:0]          gl_ro,
   output logic [2*DATA_W-1:0] gl_do,
   output logic [2*CNT_W-1:0]  occ,
   output logic [1:0]          ovf_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_lane
         logic [DATA_W-1:0] mem [DEPTH];
         logic [PTR_W-1:0]  rd_ptr;
         logic [PTR_W-1:0]  wr_ptr;
         logic [CNT_W-1:0]  count;
         logic              ovf;
         logic              full;
         logic              empty;
         logic              push;
         logic              pop;

         always_comb begin
            full  = (count == CNT_W'(DEPTH));
            empty = (count == '0);
            push  = cv_si[g] & ~full;
            pop   = ~empty & gl_ro[g];
         end

         // Storage is not reset; pointers and count define which entries are live.
         always_ff @(posedge clk) begin
            if (!reset && push) begin
               mem[wr_ptr] <= cv_di[DATA_W*g +: DATA_W];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               rd_ptr <= '0;
               wr_ptr <= '0;
               count  <= '0;
               ovf    <= 1'b0;
            end else begin
               if (push) begin
                  wr_ptr <= wr_ptr + PTR_W'(1);
               end
               if (pop) begin
                  rd_ptr <= rd_ptr + PTR_W'(1);
               end
               case ({push, pop})
                  2'b10:   count <= count + CNT_W'(1);
                  2'b01:   count <= count - CNT_W'(1);
                  default: count <= count;
               endcase
               if (cv_si[g] && full) begin
                  ovf <= 1'b1;
               end
            end
         end

         assign cv_ri[g]                     = ~full;
         assign gl_so[g]                     = pop;
         assign gl_do[DATA_W*g +: DATA_W]    = empty ? '0 : mem[rd_ptr];
         assign occ[CNT_W*g +: CNT_W]        = count;
         assign ovf_err[g]                   = ovf;
      end
   endgenerate

endmodule
